// File: rtl/uart_alu_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_frame_ctrl: collects A/B/opcode bytes, hands ALU result to UART TX
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_alu_frame_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_drop
);

  localparam int                 CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  state_t             state_q,    state_d;
  logic [NB_DATA-1:0] data_a_q,   data_a_d;
  logic [NB_DATA-1:0] data_b_q,   data_b_d;
  logic [NB_OP-1:0]   op_q,       op_d;
  logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               drop_q,     drop_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;
    cnt_d      = '0;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B, ST_WAIT_OP: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (i_rx_done) begin
          if (state_q == ST_WAIT_B) begin
            data_b_d = i_rx_data;
            state_d  = ST_WAIT_OP;
          end else begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = ST_SEND;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_WAIT_A;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SEND: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        drop_d     = i_rx_done;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        drop_d = i_rx_done;
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_drop     = drop_q;
  assign o_busy     = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);

endmodule

`default_nettype wire
